adder_operand_loader: RTL and testbench
=======================================

Name: adder_operand_loader

Overview:
Front-end control stage that sits directly upstream of the n-bit ripple adder on the FPGA board. It collects operand X, operand Y and carry-in from slide switches, one Enter button press at a time. It drives the registered operands into the adder, captures the adder's sum and carry-out into a result register, and sequences the user through LOAD_X, LOAD_Y, CALC and SHOW. The Enter button is synchronised and debounced internally.

Parameters:
n, 4, operand width; must match the adder's n.
DB_CYCLES, 500000, number of consecutive clock cycles a changed button level must hold before it is accepted; minimum 2.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
SW  input  n  operand switches.
CinSW  input  1  carry-in switch.
Enter  input  1  raw, asynchronous, bouncy pushbutton; active-high.
S  input  n  sum returned from the adder.
Cout  input  1  carry-out returned from the adder.
X  output  n  registered operand X to the adder.
Y  output  n  registered operand Y to the adder.
Cin  output  1  registered carry-in to the adder.
Result  output  n+1  captured {Cout,S}.
Valid  output  1  high while Result holds the sum of the current X, Y and Cin.
State  output  2  FSM state for the LEDs: LOAD_X=00, LOAD_Y=01, CALC=10, SHOW=11.

Behaviour:
- Reset, on a Clock edge with Reset=1:
  - X=0, Y=0, Cin=0, Result=0, Valid=0, State=LOAD_X.
  - Synchroniser flops are cleared and the debounce counter is set to 0.
  - The debounced level is set to 1, so a press is accepted only after Enter has been seen low for DB_CYCLES cycles. A button held through reset therefore produces no press.
- Synchroniser: two flops on Enter, giving 2-cycle latency.
- Debounce:
  - The counter increments while the synchronised level differs from the debounced level.
  - The counter clears to 0 on any cycle where the two levels are equal.
  - When the counter equals DB_CYCLES-1 and the levels still differ, the debounced level takes the synchronised level and the counter clears.
  - Counter width is clog2(DB_CYCLES).
- Press: a registered one-cycle pulse, asserted in the cycle after the debounced level goes 0->1. The 1->0 transition generates nothing.
- FSM transitions:
  - LOAD_X: on Press, X<=SW and go to LOAD_Y.
  - LOAD_Y: on Press, Y<=SW, Cin<=CinSW and go to CALC.
  - CALC: unconditional single cycle. Result<={Cout,S}, Valid<=1, go to SHOW. Press is ignored in this state.
  - SHOW: hold. On Press, Valid<=0 and go to LOAD_X.
- X, Y and Cin keep their values until overwritten. Switch changes never affect X, Y or Cin except in the Press cycle.
- Latency: Press in LOAD_Y during cycle t means Y/Cin are updated at the end of cycle t. The adder evaluates during cycle t+1 (CALC), and Result/Valid become visible from cycle t+2. The adder path is purely combinational from the X/Y/Cin registers and must meet one clock period.
- Arithmetic: Result is n+1 bits. The maximum sum (2^n-1)+(2^n-1)+1 = 2^(n+1)-1 fits exactly, so there is no overflow state.
- Reset asserted in any state, including CALC, overrides all other behaviour in that cycle. No partial capture occurs.
- Reset deasserted with Enter high: no Press is generated until the button is released and pressed again, each for DB_CYCLES cycles.
- Result and Valid are held constant outside CALC and reset, except that Valid clears on the SHOW->LOAD_X transition.

Test Plan:
(n=4, DB_CYCLES=4, clean presses held for at least 8 cycles, release gaps of at least 8 cycles.)
1. Basic add: press with SW=9, then press with SW=8 and CinSW=1. Required: X=9, Y=8, Cin=1, Result=5'b10010, Valid=1, State=11 exactly two cycles after the Y-capturing Press pulse.
2. Max value: X=15, Y=15, Cin=1. Required: Result=5'b11111, Valid=1. Then X=0, Y=0, Cin=0 gives Result=0.
3. Bounce rejection: in LOAD_X, Enter pulses of 1, 2 and 3 cycles separated by 1-cycle lows. Required: no Press, State stays 00, X unchanged. A subsequent 6-cycle high gives exactly one Press.
4. Reset mid-operation: Reset pulsed in LOAD_Y after X=5 was loaded. Required: next cycle X=0, Y=0, Result=0, Valid=0, State=00.
5. Held through reset: Enter=1 before, during and after a Reset pulse, held 20 cycles. Required: no Press and State stays 00. Release for 8 cycles, then press, and X is captured once.
6. Return path: in SHOW, move SW, then press. Required: Valid 1->0, State=00, X and Y retain their previous values, Result unchanged.

Source files
------------

// File: rtl/adder_operand_loader.sv
// adder_operand_loader
// Front-end control stage for an n-bit ripple adder on the FPGA board.
// The user loads operand X, then operand Y and carry-in from slide switches.
// Each value is taken on one Enter press. The stage then captures the
// adder's {Cout,S} into Result and holds it until the next press.
//
// Ports:
//   Clock   in   system clock, rising edge
//   Reset   in   synchronous, active-high reset
//   SW      in   [n-1:0] operand switches
//   CinSW   in   carry-in switch
//   Enter   in   raw asynchronous pushbutton, active-high, bouncy
//   S       in   [n-1:0] sum from the adder
//   Cout    in   carry-out from the adder
//   X, Y    out  [n-1:0] registered operands to the adder
//   Cin     out  registered carry-in to the adder
//   Result  out  [n:0] captured {Cout,S}
//   Valid   out  Result corresponds to the current X, Y, Cin
//   State   out  [1:0] LOAD_X=00, LOAD_Y=01, CALC=10, SHOW=11
module adder_operand_loader #(
  parameter int n         = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [n-1:0] SW,
  input  logic         CinSW,
  input  logic         Enter,
  input  logic [n-1:0] S,
  input  logic         Cout,
  output logic [n-1:0] X,
  output logic [n-1:0] Y,
  output logic         Cin,
  output logic [n:0]   Result,
  output logic         Valid,
  output logic [1:0]   State
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_X = 2'b00,
    LOAD_Y = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic          sync_a;
  logic          sync_b;
  logic          db_level;
  logic [CW-1:0] db_cnt;
  logic          accept;
  logic          press;

  logic          load_x;
  logic          load_y;
  logic          capture;
  logic          clear_valid;

  // The debounced level flips on the cycle the counter reaches its last value
  // while the levels still differ.
  always_comb begin
    accept = (sync_b != db_level) && (db_cnt == CNT_LAST);
  end

  // The debounced level resets high. A button that is already held therefore
  // must be seen released for the full window before any press can count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync_a <= Enter;
      sync_b <= sync_a;
      if (sync_b != db_level) begin
        if (accept) begin
          db_level <= sync_b;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      // Pulse only on the accepted 0->1 transition.
      press <= accept & sync_b;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= LOAD_X;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_x      = 1'b0;
    load_y      = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    case (state)
      LOAD_X: begin
        if (press) begin
          load_x     = 1'b1;
          state_next = LOAD_Y;
        end
      end
      LOAD_Y: begin
        if (press) begin
          load_y     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        capture    = 1'b1;
        state_next = SHOW;
      end
      SHOW: begin
        if (press) begin
          clear_valid = 1'b1;
          state_next  = LOAD_X;
        end
      end
      default: state_next = LOAD_X;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      X      <= '0;
      Y      <= '0;
      Cin    <= 1'b0;
      Result <= '0;
      Valid  <= 1'b0;
    end else begin
      if (load_x) begin
        X <= SW;
      end
      if (load_y) begin
        Y   <= SW;
        Cin <= CinSW;
      end
      if (capture) begin
        Result <= {Cout, S};
        Valid  <= 1'b1;
      end else if (clear_valid) begin
        Valid <= 1'b0;
      end
    end
  end

  assign State = state;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Testbench for adder_operand_loader (n=4, DB_CYCLES=4).
// A combinational adder model closes the loop from X/Y/Cin back to S/Cout.
// The stimulus process drives presses and keeps a reference model of the
// operand registers. It pushes each expected sum when it issues the
// Y-loading press. A separate monitor pops the expected sum on every rising
// edge of Valid and compares it.
module tb_adder_operand_loader;

  localparam int N  = 4;
  localparam int DB = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [N-1:0] SW;
  logic         CinSW;
  logic         Enter;
  logic [N-1:0] S;
  logic         Cout;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         Cin;
  logic [N:0]   Result;
  logic         Valid;
  logic [1:0]   State;

  adder_operand_loader #(.n(N), .DB_CYCLES(DB)) dut (
    .Clock(Clock), .Reset(Reset), .SW(SW), .CinSW(CinSW), .Enter(Enter),
    .S(S), .Cout(Cout), .X(X), .Y(Y), .Cin(Cin), .Result(Result),
    .Valid(Valid), .State(State)
  );

  always #5 Clock = ~Clock;

  // Board adder
  assign {Cout, S} = {1'b0, X} + {1'b0, Y} + {{N{1'b0}}, Cin};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         c;
    logic [N:0]   res;
  } exp_t;

  exp_t sb[$];
  int   pushed = 0;
  int   popped = 0;

  // Reference model of what the user has loaded so far
  logic [N-1:0] m_x, m_y;
  logic         m_c, m_valid;
  logic [N:0]   m_res;
  logic [1:0]   m_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge Clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"},  32'(State),  32'(m_state));
    check({tag, "_x"},      32'(X),      32'(m_x));
    check({tag, "_y"},      32'(Y),      32'(m_y));
    check({tag, "_cin"},    32'(Cin),    32'(m_c));
    check({tag, "_valid"},  32'(Valid),  32'(m_valid));
    check({tag, "_result"}, 32'(Result), 32'(m_res));
  endtask

  task automatic model_reset();
    m_x = '0; m_y = '0; m_c = 1'b0; m_valid = 1'b0; m_res = '0; m_state = 2'b00;
  endtask

  // One clean press with the given switch values. Switches are scrambled
  // after the hold so that later switch movement cannot leak into registers.
  task automatic do_press(input logic [N-1:0] sw, input logic cin,
                          input int hold, input int gap, input string tag);
    exp_t e;
    SW = sw;
    CinSW = cin;
    if (m_state == 2'b01) begin
      e.x = m_x; e.y = sw; e.c = cin;
      e.res = {1'b0, m_x} + {1'b0, sw} + {{N{1'b0}}, cin};
      sb.push_back(e);
      pushed++;
    end
    Enter = 1'b1;
    tick(hold);
    Enter = 1'b0;
    SW = N'($urandom_range(15));
    CinSW = 1'($urandom_range(1));
    tick(gap);
    case (m_state)
      2'b00: begin m_x = sw; m_state = 2'b01; end
      2'b01: begin
        m_y = sw; m_c = cin;
        m_res = {1'b0, m_x} + {1'b0, m_y} + {{N{1'b0}}, m_c};
        m_valid = 1'b1; m_state = 2'b11;
      end
      default: begin m_valid = 1'b0; m_state = 2'b00; end
    endcase
    check_all(tag);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    model_reset();
  endtask

  // Monitor: one comparison set for each Result presented with Valid
  initial begin : monitor
    logic       prev_valid;
    logic [1:0] prev_state;
    exp_t       e;
    prev_valid = 1'b0;
    prev_state = 2'b00;
    forever begin
      @(posedge Clock);
      #2;
      if (Valid && !prev_valid) begin
        check("mon_prev_calc", 32'(prev_state), 32'd2);
        check("mon_state_show", 32'(State), 32'd3);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: Result %0h with empty scoreboard", Result);
        end else begin
          e = sb.pop_front();
          popped++;
          check("mon_result", 32'(Result), 32'(e.res));
          check("mon_x", 32'(X), 32'(e.x));
          check("mon_y", 32'(Y), 32'(e.y));
          check("mon_cin", 32'(Cin), 32'(e.c));
        end
      end
      if (prev_state == 2'b10) check("mon_calc_to_show", 32'(State), 32'd3);
      prev_valid = Valid;
      prev_state = State;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 0};
    logic [N-1:0] sw;
    Reset = 1'b1; SW = '0; CinSW = 1'b0; Enter = 1'b0;
    model_reset();
    tick(3);
    check_all("reset");
    Reset = 1'b0;
    tick(8);
    check_all("idle");

    // Basic add: 9 + 8 + 1 = 18
    do_press(4'd9, 1'b0, 8, 8, "basic_x");
    do_press(4'd8, 1'b1, 8, 8, "basic_y");
    check("basic_result", 32'(Result), 32'h12);
    do_press(4'd3, 1'b1, 8, 8, "basic_ret");

    // Extremes
    do_press(4'd15, 1'b0, 8, 8, "max_x");
    do_press(4'd15, 1'b1, 8, 8, "max_y");
    check("max_result", 32'(Result), 32'h1f);
    do_press(4'd0, 1'b0, 8, 8, "max_ret");
    do_press(4'd0, 1'b0, 8, 8, "zero_x");
    do_press(4'd0, 1'b0, 8, 8, "zero_y");
    check("zero_result", 32'(Result), 32'h0);
    do_press(4'd7, 1'b1, 8, 8, "zero_ret");

    // Bounce rejection in LOAD_X: 1, 2 and 3 cycle pulses
    SW = 4'd6;
    foreach (pat[i]) begin
      Enter = pat[i][0];
      tick(1);
    end
    Enter = 1'b0;
    tick(8);
    check_all("bounce_reject");
    // A 6-cycle high is long enough to be accepted once
    SW = 4'd11;
    Enter = 1'b1;
    tick(6);
    Enter = 1'b0;
    tick(8);
    m_x = 4'd11; m_state = 2'b01;
    check_all("bounce_accept");
    do_press(4'd2, 1'b0, 8, 8, "bounce_y");
    do_press(4'd4, 1'b0, 8, 8, "bounce_ret");

    // Reset in LOAD_Y after X=5
    do_press(4'd5, 1'b0, 8, 8, "mid_x");
    pulse_reset();
    check_all("mid_reset");
    tick(8);

    // Enter held through reset
    Enter = 1'b1;
    tick(1);
    pulse_reset();
    tick(20);
    check_all("held_reset");
    Enter = 1'b0;
    tick(8);
    check_all("held_release");
    do_press(4'd13, 1'b0, 8, 8, "held_x");

    // Randomised traffic, starting in LOAD_Y
    for (int t = 0; t < 36; t++) begin
      sw = N'($urandom_range(15));
      do_press(sw, 1'($urandom_range(1)), 8 + int'($urandom_range(4)),
               8 + int'($urandom_range(4)), "rand");
    end

    tick(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("sb_pops", 32'(popped), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
